// File: rtl/mips32_mem_arbiter.sv
// Shares one single-ported word memory between Mips32 fetch and load/store.
// Data wins conflicts unless fetch has lost STARVE_LIMIT in a row.
module mips32_mem_arbiter #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_wen,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           stall_count
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_e;

    owner_e                owner_q, owner_d;
    logic                  d_wr_q, d_wr_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic [DATA_WIDTH-1:0] if_hold_q, d_hold_q;
    logic                  conflict;
    logic                  fetch_wins;

    always_comb begin
        conflict   = if_req & d_req;
        fetch_wins = (STARVE_LIMIT != 0) && (starve_q == LIMIT);
        if_gnt     = reset_n & if_req & (~d_req | fetch_wins);
        d_gnt      = reset_n & d_req & ~if_gnt;
        mem_en     = if_gnt | d_gnt;
        mem_wen    = d_gnt & d_wen;
        mem_addr   = d_gnt ? d_addr : if_addr;
        mem_wdata  = d_gnt ? d_wdata : '0;
    end

    always_comb begin
        owner_d  = OWN_NONE;
        d_wr_d   = d_gnt & d_wen;
        starve_d = starve_q;
        stall_d  = stall_q;
        unique case (1'b1)
            if_gnt:  owner_d = OWN_IF;
            d_gnt:   owner_d = OWN_D;
            default: owner_d = OWN_NONE;
        endcase
        if (if_gnt)
            starve_d = '0;
        else if (conflict && starve_q != LIMIT)
            starve_d = starve_q + SW'(1);
        if (conflict && stall_q != CNT_MAX)
            stall_d = stall_q + CNT_WIDTH'(1);
    end

    assign if_valid    = (owner_q == OWN_IF);
    assign d_valid     = (owner_q == OWN_D);
    assign if_rdata    = if_valid ? mem_rdata : if_hold_q;
    assign d_rdata     = (d_valid && !d_wr_q) ? mem_rdata : d_hold_q;
    assign stall_count = 32'(stall_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q   <= OWN_NONE;
            d_wr_q    <= 1'b0;
            starve_q  <= '0;
            stall_q   <= '0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            owner_q  <= owner_d;
            d_wr_q   <= d_wr_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            // Holds capture at the end of the response cycle only.
            if (if_valid)
                if_hold_q <= mem_rdata;
            if (d_valid && !d_wr_q)
                d_hold_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter: default, no-guard and
// narrow-counter instances share one stimulus stream.
module tb_mips32_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        if_req;
    logic [6:0]  if_addr;
    logic        d_req;
    logic        d_wen;
    logic [6:0]  d_addr;
    logic [31:0] d_wdata;

    logic        a_if_gnt, a_if_valid, a_d_gnt, a_d_valid;
    logic        a_mem_en, a_mem_wen;
    logic [6:0]  a_mem_addr;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata, a_stall;

    logic        b_if_gnt, b_if_valid, b_d_gnt, b_d_valid;
    logic        b_mem_en, b_mem_wen;
    logic [6:0]  b_mem_addr;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_stall;

    logic        c_if_gnt, c_if_valid, c_d_gnt, c_d_valid;
    logic        c_mem_en, c_mem_wen;
    logic [6:0]  c_mem_addr;
    logic [31:0] c_if_rdata, c_d_rdata, c_mem_wdata, c_stall;

    logic [31:0] zero_rdata = 32'd0;

    int total = 0;
    int bad   = 0;

    mips32_mem_arbiter u_a (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
        .if_valid(a_if_valid), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(a_d_gnt), .d_valid(a_d_valid), .d_rdata(a_d_rdata),
        .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .stall_count(a_stall)
    );

    mips32_mem_arbiter #(.STARVE_LIMIT(0)) u_b (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
        .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(zero_rdata),
        .stall_count(b_stall)
    );

    mips32_mem_arbiter #(.CNT_WIDTH(3)) u_c (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(c_if_gnt),
        .if_valid(c_if_valid), .if_rdata(c_if_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(c_d_gnt), .d_valid(c_d_valid), .d_rdata(c_d_rdata),
        .mem_en(c_mem_en), .mem_wen(c_mem_wen), .mem_addr(c_mem_addr),
        .mem_wdata(c_mem_wdata), .mem_rdata(zero_rdata),
        .stall_count(c_stall)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model behind instance a: 1-cycle read, write on the edge.
    logic [31:0] mem [128];
    logic        mem_loaded = 1'b0;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= 32'hA500_0000 | 32'(i);
            mem[5]     <= 32'h1234_5678;
            mem_loaded <= 1'b1;
        end else if (a_mem_en) begin
            if (a_mem_wen)
                mem[a_mem_addr] <= a_mem_wdata;
            else
                a_mem_rdata <= mem[a_mem_addr];
        end
    end

    typedef struct packed {
        logic        is_if;
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [128];
    logic        ref_loaded = 1'b0;
    logic [31:0] if_hold_exp = 32'd0;
    logic [31:0] d_hold_exp = 32'd0;

    always @(negedge clock) begin
        exp_t e;
        if (!ref_loaded) begin
            for (int i = 0; i < 128; i++)
                ref_mem[i] = 32'hA500_0000 | 32'(i);
            ref_mem[5] = 32'h1234_5678;
            ref_loaded = 1'b1;
        end
        if (!reset_n) begin
            sb.delete();
            if_hold_exp = 32'd0;
            d_hold_exp  = 32'd0;
            chk("rst_valid", 32'({a_if_valid, a_d_valid}), 32'd0);
        end else begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.is_if) begin
                    chk("sb_if_v", 32'(a_if_valid), 32'd1);
                    chk("sb_if_rd", a_if_rdata, e.data);
                    if_hold_exp = e.data;
                end else begin
                    chk("sb_d_v", 32'(a_d_valid), 32'd1);
                    chk("sb_d_rd", a_d_rdata, e.is_wr ? d_hold_exp : e.data);
                    if (!e.is_wr)
                        d_hold_exp = e.data;
                end
            end else begin
                chk("idle_valid", 32'({a_if_valid, a_d_valid}), 32'd0);
                chk("if_hold", a_if_rdata, if_hold_exp);
                chk("d_hold", a_d_rdata, d_hold_exp);
            end
            if (a_if_gnt) begin
                e = '{is_if: 1'b1, is_wr: 1'b0, data: ref_mem[if_addr]};
                sb.push_back(e);
            end
            if (a_d_gnt) begin
                e = '{is_if: 1'b0, is_wr: d_wen,
                      data: d_wen ? 32'd0 : ref_mem[d_addr]};
                sb.push_back(e);
                if (d_wen)
                    ref_mem[d_addr] = d_wdata;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_wen   = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        if_req  = 1'b1;
        if_addr = 7'd5;
        d_req   = 1'b0;
        d_wen   = 1'b0;
        d_addr  = 7'd0;
        d_wdata = 32'd0;

        @(negedge clock);
        chk("rst_if_gnt", 32'(a_if_gnt), 32'd0);
        chk("rst_mem_en", 32'(a_mem_en), 32'd0);
        chk("rst_stall", a_stall, 32'd0);
        chk("rst_if_rd", a_if_rdata, 32'd0);
        chk("rst_d_rd", a_d_rdata, 32'd0);
        step();
        if_req = 1'b0;
        step();
        reset_n = 1'b1;

        // single fetch
        step();
        if_req  = 1'b1;
        if_addr = 7'd5;
        @(negedge clock);
        chk("f_gnt", 32'({a_if_gnt, a_d_gnt}), 32'd2);
        chk("f_wen", 32'(a_mem_wen), 32'd0);
        step();
        if_req = 1'b0;
        @(negedge clock);
        chk("f_valid", 32'(a_if_valid), 32'd1);
        chk("f_rdata", a_if_rdata, 32'h1234_5678);

        // write then read-after-write
        step();
        d_req   = 1'b1;
        d_wen   = 1'b1;
        d_addr  = 7'd9;
        d_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("w_gnt", 32'(a_d_gnt), 32'd1);
        chk("w_wen", 32'(a_mem_wen), 32'd1);
        step();
        d_wen   = 1'b0;
        d_wdata = 32'd0;
        @(negedge clock);
        chk("w_ack", 32'(a_d_valid), 32'd1);
        chk("w_ack_rd", a_d_rdata, 32'd0);
        chk("w_wen_off", 32'(a_mem_wen), 32'd0);
        chk("r_gnt", 32'(a_d_gnt), 32'd1);
        step();
        d_req = 1'b0;
        @(negedge clock);
        chk("raw_valid", 32'(a_d_valid), 32'd1);
        chk("raw_rdata", a_d_rdata, 32'hDEAD_BEEF);
        step();
        @(negedge clock);
        chk("raw_hold", a_d_rdata, 32'hDEAD_BEEF);

        // sustained conflict on all three instances
        do_reset();
        step();
        if_req  = 1'b1;
        d_req   = 1'b1;
        d_wen   = 1'b0;
        if_addr = 7'd1;
        d_addr  = 7'd2;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("a_gnt", 32'({a_if_gnt, a_d_gnt}),
                (k % 5 == 4) ? 32'd2 : 32'd1);
            chk("b_gnt", 32'({b_if_gnt, b_d_gnt}), 32'd1);
            chk("c_stall", c_stall, (k < 7) ? 32'(k) : 32'd7);
            if (k == 10)
                chk("a_stall10", a_stall, 32'd10);
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clock);
        chk("a_stall20", a_stall, 32'd20);
        chk("b_stall20", b_stall, 32'd20);
        chk("c_sat", c_stall, 32'd7);

        // reset while a fetch response is outstanding
        step();
        if_req  = 1'b1;
        if_addr = 7'd5;
        @(negedge clock);
        chk("m_gnt", 32'(a_if_gnt), 32'd1);
        step();
        reset_n = 1'b0;
        if_req  = 1'b0;
        @(negedge clock);
        chk("m_valid", 32'(a_if_valid), 32'd0);
        chk("m_stall", a_stall, 32'd0);
        chk("m_rdata", a_if_rdata, 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        chk("m_novalid", 32'(a_if_valid), 32'd0);

        // back-to-back fetches after release
        step();
        if_req  = 1'b1;
        if_addr = 7'd5;
        @(negedge clock);
        chk("b2b_gnt0", 32'(a_if_gnt), 32'd1);
        step();
        if_addr = 7'd6;
        @(negedge clock);
        chk("b2b_gnt1", 32'(a_if_gnt), 32'd1);
        chk("b2b_rd0", a_if_rdata, 32'h1234_5678);
        step();
        if_addr = 7'd7;
        @(negedge clock);
        chk("b2b_rd1", a_if_rdata, 32'hA500_0006);
        step();
        if_req = 1'b0;
        @(negedge clock);
        chk("b2b_rd2", a_if_rdata, 32'hA500_0007);
        step();
        @(negedge clock);
        chk("b2b_hold", a_if_rdata, 32'hA500_0007);
        chk("b2b_idle", 32'(a_if_valid), 32'd0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
